// File: rtl/mem_write_tracer.sv
// Run-control and store-trace block: taps the data-memory write port,
// records in-window stores in a show-ahead FIFO, and ends the run on a
// store to DONE_ADDR or after TIMEOUT RUN cycles.
module mem_write_tracer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 16,
  parameter logic [ADDR_W-1:0] DONE_ADDR = 'h0000_00FC,
  parameter logic [ADDR_W-1:0] WIN_LO    = 'h0000_0000,
  parameter logic [ADDR_W-1:0] WIN_HI    = 'h0000_00FF,
  parameter int unsigned       TIMEOUT   = 60
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        overflow,
  output logic                        running,
  output logic                        done,
  output logic                        timeout,
  output logic [DATA_W-1:0]           done_value,
  output logic [$clog2(TIMEOUT):0]    cycle_count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned CW   = $clog2(TIMEOUT) + 1;

  // One-hot so each status output is a flop bit.
  localparam logic [2:0] S_RUN  = 3'b001;
  localparam logic [2:0] S_DONE = 3'b010;
  localparam logic [2:0] S_TMO  = 3'b100;

  logic [2:0]        state_q, state_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] done_value_q, done_value_d;
  logic [CW-1:0]     cycle_q, cycle_d;

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [ADDR_W-1:0] win_off;
  logic              in_win, qual, done_hit, pop, push, drop, is_full, is_run;

  assign is_run   = state_q[0];
  // Unsigned offset test avoids a constant compare when WIN_LO is zero.
  assign win_off  = addr - WIN_LO;
  assign in_win   = win_off <= (WIN_HI - WIN_LO);
  assign qual     = is_run && we && in_win;
  assign done_hit = is_run && we && (addr == DONE_ADDR);
  assign is_full  = count_q == CNTW'(DEPTH);
  assign pop      = rd_en && (count_q != '0);
  assign push     = qual && (!is_full || pop);
  assign drop     = qual && is_full && !pop;

  // Next-state for run control, FIFO bookkeeping and sticky status.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q | drop;
    done_value_d = done_value_q;
    cycle_d      = cycle_q;

    if (is_run) begin
      cycle_d = cycle_q + CW'(1);
      if (done_hit) begin
        state_d      = S_DONE;
        done_value_d = wdata;
      end else if (cycle_q == CW'(TIMEOUT - 1)) begin
        state_d = S_TMO;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_RUN;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      done_value_q <= '0;
      cycle_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      done_value_q <= done_value_d;
      cycle_q      <= cycle_d;
    end
  end

  // Trace storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_addr_q[wr_ptr_q] <= addr;
      mem_data_q[wr_ptr_q] <= wdata;
    end
  end

  assign rd_valid    = count_q != '0;
  assign rd_addr     = mem_addr_q[rd_ptr_q];
  assign rd_data     = mem_data_q[rd_ptr_q];
  assign count       = count_q;
  assign full        = is_full;
  assign overflow    = overflow_q;
  assign running     = state_q[0];
  assign done        = state_q[1];
  assign timeout     = state_q[2];
  assign done_value  = done_value_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_mem_write_tracer.sv
// Directed bench for mem_write_tracer: the stimulus pushes expected trace
// entries into a scoreboard queue, a negedge monitor checks every pop.
module tb_mem_write_tracer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rd_valid, full, overflow, running, done, timeout;
  logic [31:0] rd_addr, rd_data, done_value;
  logic [4:0]  count;
  logic [6:0]  cycle_count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int   total = 0;
  int   bad = 0;

  mem_write_tracer #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(16), .DONE_ADDR(32'h0000_00FC),
    .WIN_LO(32'h0000_0000), .WIN_HI(32'h0000_00FF), .TIMEOUT(60)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .full(full), .overflow(overflow), .running(running),
    .done(done), .timeout(timeout), .done_value(done_value),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every pop the DUT performs must match the scoreboard head.
  always @(negedge clk) begin
    if (reset && rd_en && rd_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got addr %0h data %0h, expected no entry", rd_addr, rd_data);
      end else begin
        mon_e = sb.pop_front();
        chk("pop_addr", {32'h0, rd_addr}, {32'h0, mon_e.a});
        chk("pop_data", {32'h0, rd_data}, {32'h0, mon_e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit cap);
    we = 1'b1;
    addr = a;
    wdata = d;
    if (cap) sb.push_back('{a: a, d: d});
    tick();
    we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    we = 1'b0;
    rd_en = 1'b0;
    tick();
    tick();
    sb.delete();
    chk("rst_running", 64'(running), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_cycle", 64'(cycle_count), 64'd0);
    chk("rst_done_value", 64'(done_value), 64'd0);
    reset = 1'b1;
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset and free-running cycle counter.
    do_reset();
    tick();
    chk("cyc_1", 64'(cycle_count), 64'd1);
    tick();
    chk("cyc_2", 64'(cycle_count), 64'd2);
    chk("cyc_running", 64'(running), 64'd1);

    // Window filtering and FIFO order.
    do_reset();
    store(32'h10, 32'hA, 1'b1);
    store(32'h14, 32'hB, 1'b1);
    store(32'h200, 32'hC, 1'b0);
    chk("win_count", 64'(count), 64'd2);
    chk("win_rd_valid", 64'(rd_valid), 64'd1);
    drain(2);
    chk("win_empty", 64'(rd_valid), 64'd0);
    chk("win_count0", 64'(count), 64'd0);
    chk("win_sb_empty", 64'(sb.size()), 64'd0);

    // Done store at cycle 5.
    do_reset();
    repeat (5) tick();
    store(32'hFC, 32'h7, 1'b1);
    chk("dn_done", 64'(done), 64'd1);
    chk("dn_running", 64'(running), 64'd0);
    chk("dn_timeout", 64'(timeout), 64'd0);
    chk("dn_value", 64'(done_value), 64'h7);
    chk("dn_cycle", 64'(cycle_count), 64'd6);
    chk("dn_count", 64'(count), 64'd1);
    store(32'h20, 32'h55, 1'b0);
    store(32'hFC, 32'h99, 1'b0);
    chk("dn_ignored_count", 64'(count), 64'd1);
    chk("dn_frozen_cycle", 64'(cycle_count), 64'd6);
    chk("dn_value_hold", 64'(done_value), 64'h7);
    drain(1);
    chk("dn_drained", 64'(rd_valid), 64'd0);
    chk("dn_sb_empty", 64'(sb.size()), 64'd0);

    // Timeout after the 60th RUN cycle.
    do_reset();
    repeat (59) tick();
    chk("tmo_pre_cycle", 64'(cycle_count), 64'd59);
    chk("tmo_pre_running", 64'(running), 64'd1);
    tick();
    chk("tmo_timeout", 64'(timeout), 64'd1);
    chk("tmo_running", 64'(running), 64'd0);
    chk("tmo_cycle", 64'(cycle_count), 64'd60);
    store(32'h30, 32'h1, 1'b0);
    chk("tmo_frozen", 64'(cycle_count), 64'd60);
    chk("tmo_no_capture", 64'(count), 64'd0);

    // Done store on the timeout cycle takes priority.
    do_reset();
    repeat (59) tick();
    store(32'hFC, 32'h3C, 1'b1);
    chk("race_done", 64'(done), 64'd1);
    chk("race_timeout", 64'(timeout), 64'd0);
    chk("race_value", 64'(done_value), 64'h3C);
    chk("race_cycle", 64'(cycle_count), 64'd60);
    drain(1);
    chk("race_sb_empty", 64'(sb.size()), 64'd0);

    // Overflow: 17th store dropped when full without a pop.
    do_reset();
    for (int i = 0; i < 17; i++)
      store(32'(4 * i), 32'h100 + 32'(i), i < 16);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    drain(16);
    chk("ovf_drained", 64'(rd_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("ovf_sb_empty", 64'(sb.size()), 64'd0);

    // Push and pop together at full: no drop, order kept.
    do_reset();
    for (int i = 0; i < 16; i++)
      store(32'h40 + 32'(4 * i), 32'h200 + 32'(i), 1'b1);
    chk("pp_full_before", 64'(full), 64'd1);
    rd_en = 1'b1;
    store(32'h80, 32'h2FF, 1'b1);
    rd_en = 1'b0;
    chk("pp_count", 64'(count), 64'd16);
    chk("pp_full", 64'(full), 64'd1);
    chk("pp_overflow", 64'(overflow), 64'd0);
    drain(11);
    chk("pp_count5", 64'(count), 64'd5);

    // Reset in the middle of a drain discards the FIFO.
    reset = 1'b0;
    rd_en = 1'b1;
    tick();
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_overflow", 64'(overflow), 64'd0);
    chk("mid_running", 64'(running), 64'd1);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_rd_valid", 64'(rd_valid), 64'd0);
    sb.delete();
    rd_en = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_after_cycle", 64'(cycle_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_write_tracer.md
Name: mem_write_tracer

Overview:
- Parametrised run-control and store-trace block, instantiated beside the processor top, tapping the data-memory write port (we/address/write data).
- Captures qualifying stores into an internal FIFO, detects program completion via a store to a designated "done" address, and enforces a cycle-count timeout.
- Gives simulation and on-board debug a uniform termination and trace mechanism in place of fixed-duration runs.

Parameters:
- ADDR_W, 32, address width of the monitored write port
- DATA_W, 32, data width of the monitored write port
- DEPTH, 16, trace FIFO entries (power of two, >=2)
- DONE_ADDR, 32'h0000_00FC, store to this address ends the run
- WIN_LO, 32'h0000_0000, lowest captured address (inclusive)
- WIN_HI, 32'h0000_00FF, highest captured address (inclusive)
- TIMEOUT, 60, maximum RUN cycles before forced stop (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- we  in  1  data-memory write enable from processor
- addr  in  ADDR_W  data-memory address from processor
- wdata  in  DATA_W  data-memory write data from processor
- rd_en  in  1  pop request for trace FIFO
- rd_valid  out  1  FIFO non-empty; rd_addr/rd_data valid
- rd_addr  out  ADDR_W  address of FIFO head entry
- rd_data  out  DATA_W  data of FIFO head entry
- count  out  log2(DEPTH)+1  current FIFO occupancy
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a qualifying store was dropped
- running  out  1  state == RUN
- done  out  1  state == DONE
- timeout  out  1  state == TMO
- done_value  out  DATA_W  wdata of the terminating store
- cycle_count  out  log2(TIMEOUT)+1  RUN cycles elapsed

Behaviour:
- Reset (reset==0 at clk edge): state=RUN; count=0, FIFO pointers=0, overflow=0, done_value=0, cycle_count=0. Outputs after reset: running=1, done=0, timeout=0, rd_valid=0, full=0. Reset overrides all other activity, including mid-run and mid-drain; FIFO contents are discarded.
- States: RUN, DONE, TMO. DONE and TMO are terminal; exit only via reset.
- Qualifying store: state==RUN && we==1 && WIN_LO<=addr<=WIN_HI.
- RUN -> DONE: qualifying-or-not store with we==1 && addr==DONE_ADDR; done_value<=wdata same edge. Terminating store is also captured if inside window.
- RUN -> TMO: cycle_count==TIMEOUT-1 at the edge with no done store that cycle. Done store in the same cycle wins (-> DONE).
- cycle_count increments by 1 each RUN cycle; frozen in DONE/TMO.
- FIFO is show-ahead: rd_addr/rd_data reflect head combinationally whenever rd_valid=1; undefined-but-stable (hold last) when empty.
- Pop: rd_en && rd_valid removes head at edge; rd_en on empty ignored, no underflow.
- Push: qualifying store written at edge if !full, or if full and pop occurs same edge (simultaneous push+pop at full keeps count=DEPTH).
- Push when full with no pop: store dropped, overflow<=1 (sticky until reset).
- Simultaneous push+pop at non-empty: count unchanged; ordering strictly FIFO.
- Pointers wrap modulo DEPTH; count is exact 0..DEPTH.
- Draining permitted in all states; capture only in RUN.
- All outputs registered except rd_valid/rd_addr/rd_data/full (decoded from registered state).

Test Plan:
- Reset held 0 for 2 cycles, then 1 with we=0 -> running=1, count=0, rd_valid=0, cycle_count counts 0,1,2...
- Stores (addr,data) = (0x10,0xA),(0x14,0xB),(0x200,0xC) -> count=2 (0x200 outside window); pops return (0x10,0xA) then (0x14,0xB), then rd_valid=0.
- Store (0xFC,0x7) at cycle 5 -> done=1, done_value=0x7, running=0, FIFO holds (0xFC,0x7), cycle_count frozen at 6; later stores ignored.
- No done store, TIMEOUT=60 -> timeout=1 after 60th RUN cycle, cycle_count=60; done store on cycle 60 instead -> done=1, timeout=0.
- 17 stores, DEPTH=16, no pops -> count=16, full=1, overflow=1, 17th absent; repeat with rd_en=1 on 17th store -> count stays 16, overflow=0, order preserved.
- Reset asserted mid-drain with count=5 -> next cycle count=0, overflow=0, running=1, done=0.
